cnn_uart_tx: RTL and testbench

- Serial transmitter at the far end of the CNN core's byte-output handshake.
- Accepts a byte on `tx_data` when `trmt` pulses and shifts it out on `TX` as 8N1 UART: start bit, 8 data bits LSB first, stop bit.
- Reports completion back to the core on `tx_done`.
- Sits between the CNN core result path and the DE0-Nano UART pin.

---
 rtl/cnn_uart_pkg.sv | 22 ++
 rtl/cnn_uart_baud_gen.sv | 34 +++
 rtl/cnn_uart_tx.sv | 98 +++++++++
 tb/tb_cnn_uart_tx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cnn_uart_pkg.sv
// Shared UART definitions: state encoding, frame geometry and default baud divisor.
// CNN_UART_TX_PARITY_EN adds an even-parity bit, which makes the frame 11 bits.
package cnn_uart_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XMIT = 1'b1
  } tx_state_t;

  localparam int DATA_BITS = 8;

`ifdef CNN_UART_TX_PARITY_EN
  localparam int FRAME_BITS = DATA_BITS + 3;  // start, data, parity, stop
`else
  localparam int FRAME_BITS = DATA_BITS + 2;  // start, data, stop
`endif

  // 50 MHz / 115200 baud, shared with the receive side
  localparam int BAUD_DIV_DEFAULT = 434;
  localparam int BAUD_W_DEFAULT   = 9;

endpackage

// File: rtl/cnn_uart_baud_gen.sv
// Bit-period timer for the UART transmitter: counts clk cycles while enabled
// and emits a one-cycle tick at the last cycle of each bit period.
module cnn_uart_baud_gen #(
  parameter int BAUD_DIV = 434,
  parameter int BAUD_W   = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  logic [BAUD_W-1:0] cnt_q, cnt_d;
  logic              last;

  assign last   = (cnt_q == BAUD_W'(BAUD_DIV - 1));
  assign tick_o = en_i & last;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last ? '0 : cnt_q + BAUD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cnn_uart_tx.sv
// UART transmitter for the CNN core byte-output path (8N1, LSB first).
// Define CNN_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module cnn_uart_tx
  import cnn_uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT,
  parameter int BAUD_W   = BAUD_W_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_bsy,
  output logic       tx_done
);

  tx_state_t             state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic                  bsy_q, bsy_d;
  logic                  done_q, done_d;
  logic                  load;
  logic                  bit_tick;
  logic [FRAME_BITS-1:0] frame_load;

`ifdef CNN_UART_TX_PARITY_EN
  assign frame_load = {1'b1, ^tx_data, tx_data, 1'b0};
`else
  assign frame_load = {1'b1, tx_data, 1'b0};
`endif

  cnn_uart_baud_gen #(
    .BAUD_DIV (BAUD_DIV),
    .BAUD_W   (BAUD_W)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (load),
    .en_i   (state_q == XMIT),
    .tick_o (bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    bsy_d     = bsy_q;
    done_d    = done_q;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (trmt) begin
          load      = 1'b1;
          shift_d   = frame_load;
          bit_cnt_d = '0;
          bsy_d     = 1'b1;
          done_d    = 1'b0;
          state_d   = XMIT;
        end
      end
      XMIT: begin
        if (bit_tick) begin
          shift_d   = {1'b1, shift_q[FRAME_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          // last tick closes the stop bit; requests this cycle are dropped
          if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
            state_d = IDLE;
            bsy_d   = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '1;
      bit_cnt_q <= '0;
      bsy_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      bsy_q     <= bsy_d;
      done_q    <= done_d;
    end
  end

  assign TX      = shift_q[0];
  assign tx_bsy  = bsy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_cnn_uart_tx.sv
// Self-checking bench for cnn_uart_tx at BAUD_DIV=4: table vectors, random bytes
// against a frame model, plus reset, sticky-done and ignored-request sequences.
module tb_cnn_uart_tx;

  localparam int BD = 4;
`ifdef CNN_UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int NCYC = FB * BD;

  logic       clk = 1'b0;
  logic       rst;
  logic       trmt;
  logic [7:0] tx_data;
  logic       TX, tx_bsy, tx_done;

  int checks   = 0;
  int failures = 0;

  cnn_uart_tx #(.BAUD_DIV(BD), .BAUD_W(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .trmt    (trmt),
    .tx_data (tx_data),
    .TX      (TX),
    .tx_bsy  (tx_bsy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] line;   // bit i is the i-th bit on the wire
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Wire sequence built directly from the frame rules: start, data LSB first, [parity], stop
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic bits[$];
    logic [10:0] r;
    logic p;
    p = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      bits.push_back(d[i]);
      p = p ^ d[i];
    end
`ifdef CNN_UART_TX_PARITY_EN
    bits.push_back(p);
`endif
    bits.push_back(1'b1);
    r = '1;
    for (int i = 0; i < bits.size(); i++) r[i] = bits[i];
    return r;
  endfunction

  // Called at a negedge with the bench idle. Returns at the negedge where tx_done first reads 1.
  task automatic run_frame(input logic [7:0] d, input logic [10:0] exp, input int inject_at);
    trmt = 1'b1;
    tx_data = d;
    @(negedge clk);
    trmt = 1'b0;
    for (int c = 1; c <= NCYC + 1; c++) begin
      if (c <= NCYC) begin
        chk("tx_line", TX, exp[(c-1)/BD]);
        chk("tx_bsy_frame", tx_bsy, 1'b1);
        chk("tx_done_low", tx_done, 1'b0);
      end else begin
        chk("tx_done_rise", tx_done, 1'b1);
        chk("tx_bsy_end", tx_bsy, 1'b0);
        chk("tx_idle_end", TX, 1'b1);
      end
      tx_data = 8'($urandom);
      if (inject_at != 0 && c == inject_at) begin
        trmt = 1'b1;
        tx_data = 8'h3C;
      end else begin
        trmt = 1'b0;
      end
      if (c <= NCYC) @(negedge clk);
    end
    trmt = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
`ifdef CNN_UART_TX_PARITY_EN
    tbl[0] = '{8'hA5, 11'h54A};
    tbl[1] = '{8'h00, 11'h400};
    tbl[2] = '{8'hFF, 11'h5FE};
    tbl[3] = '{8'h07, 11'h60E};
    tbl[4] = '{8'h03, 11'h406};
`else
    tbl[0] = '{8'hA5, 11'h34A};
    tbl[1] = '{8'h00, 11'h200};
    tbl[2] = '{8'hFF, 11'h3FE};
    tbl[3] = '{8'h55, 11'h2AA};
    tbl[4] = '{8'h3C, 11'h278};
`endif

    rst = 1'b1;
    trmt = 1'b0;
    tx_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_TX", TX, 1'b1);
    chk("rst_bsy", tx_bsy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // A5 frame, then tx_done must hold while idle
    run_frame(tbl[0].data, tbl[0].line, 0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("done_sticky", tx_done, 1'b1);
      chk("idle_TX", TX, 1'b1);
    end

    // Remaining entries back to back: each trmt lands the cycle after tx_done rises
    for (int i = 1; i < 5; i++) run_frame(tbl[i].data, tbl[i].line, 0);

    // Request mid-frame must be ignored
    @(negedge clk);
    run_frame(8'hFF, model_frame(8'hFF), 15);
    for (int i = 0; i < 3 * BD; i++) begin
      @(negedge clk);
      chk("no_second_start", TX, 1'b1);
      chk("no_second_bsy", tx_bsy, 1'b0);
      chk("done_once", tx_done, 1'b1);
    end

    // Random bytes against the model
    for (int n = 0; n < 8; n++) begin
      d = 8'($urandom);
      run_frame(d, model_frame(d), (n % 2 == 1) ? 5 + n : 0);
    end

    // Async reset during data bit 3 of 8'h55 (a 0 on the wire)
    @(negedge clk);
    trmt = 1'b1;
    tx_data = 8'h55;
    @(negedge clk);
    trmt = 1'b0;
    repeat (4 * BD + 1) @(negedge clk);
    chk("pre_rst_TX", TX, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async_TX", TX, 1'b1);
    chk("async_bsy", tx_bsy, 1'b0);
    chk("async_done", tx_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2 * NCYC; i++) begin
      @(negedge clk);
      chk("post_rst_TX", TX, 1'b1);
      chk("post_rst_bsy", tx_bsy, 1'b0);
      chk("post_rst_done", tx_done, 1'b0);
    end

    // Transmitter still works after the abandoned frame
    run_frame(tbl[3].data, tbl[3].line, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
